// File: rtl/serial_tx.sv
// Serial transmitter: start bit, LSB-first payload, optional even parity, one stop bit.
// Each bit lasts CLKS_PER_BIT clocks, and tx comes straight from a flop.
module serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 send,
    output logic                 ready,
    output logic                 tx,
    output logic                 done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 bit_end_s;

    // State register and datapath flops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    // Next-state logic, bit timing and the value tx takes next cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        tx_d      = 1'b1;
        bit_end_s = (cnt_q == CNT_MAX);

        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (bit_end_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (send) begin
                    state_d  = START;
                    shreg_d  = data;
                    parity_d = ^data;
                    idx_d    = '0;
                end
            end
            START: begin
                if (bit_end_s) state_d = DATA;
            end
            DATA: begin
                if (bit_end_s) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IDX_MAX) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end_s) state_d = STOP;
            end
            STOP: begin
                if (bit_end_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // tx is derived from the next state so the flop already holds the bit
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == STOP) && (cnt_q == CNT_MAX);
    assign tx    = tx_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: one instance without parity, one with, both at 4 clocks per bit.
// A negedge monitor compares every line cycle against frames queued by the stimulus.
module tb_serial_tx;

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic       par;
        int         len;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] send_w = 2'b00;
    logic [7:0] data_w [2];
    logic [1:0] ready_w, tx_w, done_w;

    int tests_run = 0;
    int tests_failed = 0;

    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [11:0] cur [2];
    int          pos [2];
    int          pushed [2];
    int          done_seen [2];

    serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0)) dut0 (
        .clock(clock), .reset(reset), .data(data_w[0]), .send(send_w[0]),
        .ready(ready_w[0]), .tx(tx_w[0]), .done(done_w[0])
    );

    serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1)) dut1 (
        .clock(clock), .reset(reset), .data(data_w[1]), .send(send_w[1]),
        .ready(ready_w[1]), .tx(tx_w[1]), .done(done_w[1])
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected line bits, index 0 = start bit
    task automatic push(input int i, input logic [7:0] d, input logic par);
        logic [11:0] b;
        if (i == 0) b = {3'b111, d, 1'b0};
        else        b = {2'b11, par, d, 1'b0};
        if (i == 0) q0.push_back(b);
        else        q1.push_back(b);
        pushed[i]++;
    endtask

    task automatic mon_step(input int i);
        int L;
        int k;
        int qs;
        L  = (i == 0) ? 40 : 44;
        qs = (i == 0) ? q0.size() : q1.size();
        if (done_w[i] === 1'b1 && !reset) done_seen[i]++;
        if (reset) begin
            pos[i] = 0;
            chk("reset_tx", {31'd0, tx_w[i]}, 32'd1);
            chk("reset_done", {31'd0, done_w[i]}, 32'd0);
            chk("reset_ready", {31'd0, ready_w[i]}, 32'd1);
        end else begin
            if (pos[i] == 0) begin
                chk("idle_done", {31'd0, done_w[i]}, 32'd0);
                if (tx_w[i] === 1'b0) begin
                    chk("frame_expected", {31'd0, qs != 0}, 32'd1);
                    if (qs != 0) begin
                        cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
                        pos[i] = 1;
                    end
                end else begin
                    chk("idle_ready", {31'd0, ready_w[i]}, 32'd1);
                end
            end
            if (pos[i] != 0) begin
                k = pos[i];
                chk("tx_bit", {31'd0, tx_w[i]}, {31'd0, cur[i][(k - 1) / 4]});
                chk("done_pulse", {31'd0, done_w[i]}, {31'd0, k == L});
                chk("busy_ready", {31'd0, ready_w[i]}, 32'd0);
                pos[i] = (k == L) ? 0 : k + 1;
            end
        end
    endtask

    // Line monitor for both instances
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) mon_step(i);
    end

    task automatic start_frame(input int i, input logic [7:0] d, input logic par);
        int n;
        n = 0;
        @(negedge clock);
        while (ready_w[i] !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("wait_ready", {31'd0, ready_w[i]}, 32'd1);
        data_w[i] = d;
        send_w[i] = 1'b1;
        push(i, d, par);
        @(posedge clock);
        #1;
        send_w[i] = 1'b0;
        data_w[i] = ~d;
    endtask

    // Counts cycles from acceptance to done, then expects ready the cycle after
    task automatic finish_frame(input int i, input int L, input int c0);
        int c;
        c = c0;
        do begin
            @(negedge clock);
            c++;
        end while (done_w[i] !== 1'b1 && c < L + 50);
        chk("done_cycle", c, L);
        @(negedge clock);
        chk("ready_after", {31'd0, ready_w[i]}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        vecs[0] = '{sel: 0, d: 8'hA5, par: 1'b0, len: 40};
        vecs[1] = '{sel: 1, d: 8'h07, par: 1'b1, len: 44};
        vecs[2] = '{sel: 1, d: 8'h03, par: 1'b0, len: 44};
        vecs[3] = '{sel: 0, d: 8'h00, par: 1'b0, len: 40};
        vecs[4] = '{sel: 0, d: 8'hFF, par: 1'b0, len: 40};
        vecs[5] = '{sel: 1, d: 8'h80, par: 1'b1, len: 44};
        vecs[6] = '{sel: 1, d: 8'hFF, par: 1'b0, len: 44};
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; pushed[i] = 0; done_seen[i] = 0; data_w[i] = 8'h00;
        end

        // Request pending while in reset: accepted on the first edge after release
        data_w[0] = 8'h3C;
        send_w[0] = 1'b1;
        push(0, 8'h3C, 1'b0);
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        send_w[0] = 1'b0;
        data_w[0] = 8'h00;
        chk("accept_after_reset_tx", {31'd0, tx_w[0]}, 32'd0);
        finish_frame(0, 40, 0);

        for (int v = 0; v < 7; v++) begin
            start_frame(vecs[v].sel, vecs[v].d, vecs[v].par);
            finish_frame(vecs[v].sel, vecs[v].len, 0);
        end

        // send held high with data changing: two frames, one idle cycle between
        @(negedge clock);
        data_w[0] = 8'h11;
        send_w[0] = 1'b1;
        push(0, 8'h11, 1'b0);
        @(posedge clock);
        #1 data_w[0] = 8'h22;
        push(0, 8'h22, 1'b0);
        finish_frame(0, 40, 0);
        chk("gap_tx", {31'd0, tx_w[0]}, 32'd1);
        @(posedge clock);
        #1;
        send_w[0] = 1'b0;
        data_w[0] = 8'h5A;
        chk("gap_one_cycle_ready", {31'd0, ready_w[0]}, 32'd0);
        chk("gap_one_cycle_tx", {31'd0, tx_w[0]}, 32'd0);
        finish_frame(0, 40, 0);

        // send pulsed mid-DATA is ignored
        start_frame(0, 8'hC3, 1'b0);
        repeat (12) @(negedge clock);
        data_w[0] = 8'hFF;
        send_w[0] = 1'b1;
        chk("busy_send_ready", {31'd0, ready_w[0]}, 32'd0);
        @(posedge clock);
        #1 send_w[0] = 1'b0;
        finish_frame(0, 40, 12);
        repeat (60) @(negedge clock);
        chk("no_second_frame_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("no_second_frame_ready", {31'd0, ready_w[0]}, 32'd1);

        // Reset during data bit 3 aborts at once; next frame is complete
        start_frame(0, 8'hA5, 1'b0);
        repeat (18) @(negedge clock);
        chk("bit3_before_reset", {31'd0, tx_w[0]}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("async_reset_done", {31'd0, done_w[0]}, 32'd0);
        chk("async_reset_ready", {31'd0, ready_w[0]}, 32'd1);
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
        start_frame(0, 8'hA5, 1'b0);
        finish_frame(0, 40, 0);

        repeat (5) @(negedge clock);
        chk("queue0_empty", q0.size(), 32'd0);
        chk("queue1_empty", q1.size(), 32'd0);
        chk("done_count0", done_seen[0], pushed[0] - 1);
        chk("done_count1", done_seen[1], pushed[1]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
